bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequential binary-to-BCD converter and display sequencer for the board's seven-segment bank. Accepts a WIDTH-bit unsigned value over a ready/load handshake and converts it with a one-bit-per-cycle double-dabble. Publishes DIGITS packed BCD nibbles in one update, one nibble per BCD-to-seven-segment decoder instance. Nibble code 4'hF is the blank code; the decoders turn every segment off for codes 10-15.

## Interface
- WIDTH, 16, bit width of the binary input; legal range 4 to 32.
- DIGITS, 5, number of BCD digits produced; legal range 1 to 10.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  WIDTH  unsigned binary operand; sampled only on an accepted load.
- load  in  1  request a conversion of value.
- ready  out  1  high when the block is idle and can accept a load.
- digits_out  out  4*DIGITS  BCD result, digit 0 (units) in bits [3:0]; held between updates.
- done  out  1  one-cycle pulse in the cycle digits_out takes a new value.
- ovf  out  1  high when the last value did not fit in DIGITS digits; held until the next update.

## Operation
- Reset values: the FSM goes to IDLE, ready=1, done=0, ovf=0, digits_out all 4'hF (display blank).
- FSM states: IDLE, CONV.
- IDLE -> CONV: on a rising edge with load=1 and ready=1. That edge loads value into a WIDTH-bit shift register, clears the 4*DIGITS BCD accumulator, clears the overflow sticky bit, and loads the bit counter with WIDTH.
- CONV, every edge, in this order:
  - Add 3 to each accumulator nibble that is 5 or greater.
  - Shift {accumulator, shift register} left by one.
  - If the bit shifted out of the top nibble is 1, set the overflow sticky bit.
  - Decrement the bit counter.
- CONV -> IDLE: on the edge where the counter goes from 1 to 0.
  - That same edge registers the result into digits_out and sets done=1.
  - It also copies the overflow sticky bit to ovf.
- Overflow result: digits_out is all 4'hF, not a truncated number.
- During CONV:
  - ready=0.
  - load is ignored and does not queue.
  - value may change freely.
- Accumulator nibble arithmetic is 4 bits wide. Adjusted nibbles never exceed 12, so no nibble-to-nibble carry exists other than the shift.

## Timing
- Load accepted at edge E0.
- ready falls in the cycle after E0.
- digits_out, ovf and done update at edge E0+WIDTH.
- done is high for exactly the cycle following E0+WIDTH.
- ready returns high in that same cycle.
- A load held high in the done cycle is accepted at edge E0+WIDTH+1, so back-to-back throughput is one conversion per WIDTH+1 cycles.
- Reset asserted mid-conversion:
  - aborts immediately and asynchronously;
  - forces the reset values above;
  - leaves no partial result visible on digits_out.
- With DIGITS*4 >= WIDTH+WIDTH/3+1, ovf can never assert. Both the default parameters and the DIGITS=4 overflow case are required configurations.

## Configuration
- BCD_LEAD_BLANK_EN defined:
  - On update, every digit above the most significant non-zero digit is replaced with 4'hF.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking does not apply to overflow results, which are already all 4'hF.
- BCD_LEAD_BLANK_EN not defined:
  - digits_out carries raw BCD with leading zeros.
  - Latency and handshake are identical in both builds.

## Test plan
- Reset, then idle 5 cycles -> ready=1, done=0, ovf=0, digits_out=20'hFFFFF.
- Load value=0 -> done at E0+16; digits_out=20'h00000 without the macro, 20'hFFFF0 with it; ovf=0.
- Load value=1234 -> digits_out=20'h01234 without the macro, 20'hF1234 with it; load then held high -> second conversion accepted at edge E0+17.
- Load value=65535 -> digits_out=20'h65535, ovf=0; load pulsed during CONV -> ignored, exactly one done pulse.
- Parameters DIGITS=4, WIDTH=16; load value=12345 -> ovf=1, digits_out=16'hFFFF; then load 9999 -> ovf=0, digits_out=16'h9999.
- Load value=42, assert rst_n=0 at E0+8 for 2 cycles -> outputs return to reset values immediately, no done pulse; a fresh load of 42 gives digits_out=20'h00042 (20'hFFF42 with the macro).

Source files
------------

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: sequential binary-to-BCD converter (double-dabble, one bit
// per cycle) driving a bank of BCD-to-seven-segment decoders.
// Optional build macro: BCD_LEAD_BLANK_EN replaces leading zero digits with the
// blank code 4'hF. Digit 0 is never blanked.
module bcd_display_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  done,
  output logic                  ovf
);

  localparam int unsigned AW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [AW-1:0]    acc_adj, acc_shift, result;
  logic             sticky, sticky_nxt, ovf_now;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ready_nxt, done_nxt, ovf_nxt;
  logic [AW-1:0]    digits_nxt;

  // Add-3 adjustment of every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // One-bit shift of {accumulator, operand}; the bit leaving the top nibble is lost range.
  always_comb begin
    acc_shift = {acc_adj[AW-2:0], shreg[WIDTH-1]};
    ovf_now   = sticky | acc_adj[AW-1];
  end

`ifdef BCD_LEAD_BLANK_EN
  logic lead;

  // Blank digits above the most significant non-zero digit; overflow shows all blank.
  always_comb begin
    result = acc_shift;
    lead   = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead && (acc_shift[4*i +: 4] == 4'd0)) begin
        result[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    if (ovf_now) begin
      result = '1;
    end
  end
`else
  // Raw BCD with leading zeros; overflow shows all blank.
  always_comb begin
    result = acc_shift;
    if (ovf_now) begin
      result = '1;
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    cnt_nxt    = cnt;
    ready_nxt  = ready;
    done_nxt   = 1'b0;
    ovf_nxt    = ovf;
    digits_nxt = digits_out;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt  = CONV;
          shreg_nxt  = value;
          acc_nxt    = '0;
          sticky_nxt = 1'b0;
          cnt_nxt    = CW'(WIDTH);
          ready_nxt  = 1'b0;
        end
      end
      CONV: begin
        shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
        acc_nxt    = acc_shift;
        sticky_nxt = ovf_now;
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt  = IDLE;
          ready_nxt  = 1'b1;
          done_nxt   = 1'b1;
          ovf_nxt    = ovf_now;
          digits_nxt = result;
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset blanks the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      acc        <= '0;
      sticky     <= 1'b0;
      cnt        <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      ovf        <= 1'b0;
      digits_out <= '1;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      acc        <= acc_nxt;
      sticky     <= sticky_nxt;
      cnt        <= cnt_nxt;
      ready      <= ready_nxt;
      done       <= done_nxt;
      ovf        <= ovf_nxt;
      digits_out <= digits_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Testbench for bcd_display_ctrl: default 5-digit build and a 4-digit build
// (overflow case) driven by the same stimulus, checked against a decimal model.
module tb_bcd_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;

  logic        ready5, done5, ovf5;
  logic [19:0] digits5;
  logic        ready4, done4, ovf4;
  logic [15:0] digits4;

  int n_checks;
  int n_fail;

`ifdef BCD_LEAD_BLANK_EN
  localparam logic [3:0] LEAD = 4'hF;
`else
  localparam logic [3:0] LEAD = 4'h0;
`endif

  bcd_display_ctrl #(.WIDTH(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .ready(ready5), .digits_out(digits5), .done(done5), .ovf(ovf5)
  );

  bcd_display_ctrl #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .ready(ready4), .digits_out(digits4), .done(done4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal rendering of v on n digits: all blank when it does not fit.
  function automatic logic [39:0] model_digits(input longint unsigned v, input int n);
    logic [39:0] r;
    longint unsigned p;
    r = '0;
    if (v >= pow10(n)) begin
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'hF;
      return r;
    end
    p = 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || v >= p) r[4*i +: 4] = 4'((v / p) % 10);
      else                  r[4*i +: 4] = LEAD;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input longint unsigned v, input int n);
    return v >= pow10(n);
  endfunction

  // Present a load at the next cycle and confirm it is taken on the following edge.
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    check("ready_before_load", 40'(ready5), 40'(1'b1));
    value = v;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check("ready_low_after_accept", 40'(ready5), 40'(1'b0));
    check("ready4_low_after_accept", 40'(ready4), 40'(1'b0));
  endtask

  // From the cycle after acceptance, wait (bounded) for done and check the result.
  task automatic wait_result(input logic [15:0] v, input bit pulse);
    int lat;
    lat = 0;
    while (done5 !== 1'b1 && lat < 40) begin
      if (pulse && lat < 12) load = 1'($urandom_range(0, 1));
      else                   load = 1'b0;
      value = 16'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    load = 1'b0;
    check("latency", 40'(lat), 40'(16));
    check("done4", 40'(done4), 40'(1'b1));
    check("digits5", 40'(digits5), model_digits(64'(v), 5));
    check("digits4", 40'(digits4), model_digits(64'(v), 4));
    check("ovf5", 40'(ovf5), 40'(model_ovf(64'(v), 5)));
    check("ovf4", 40'(ovf4), 40'(model_ovf(64'(v), 4)));
    check("ready_in_done", 40'(ready5), 40'(1'b1));
  endtask

  // Idle cycles after a result: no further done pulse, result held.
  task automatic quiet(input logic [15:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_single_pulse", 40'(done5 | done4), 40'(1'b0));
      check("digits5_held", 40'(digits5), model_digits(64'(v), 5));
    end
  endtask

  initial begin
    logic [15:0] v;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ready", 40'(ready5), 40'(1'b1));
    check("rst_done", 40'(done5), 40'(1'b0));
    check("rst_ovf", 40'(ovf5), 40'(1'b0));
    check("rst_digits5", 40'(digits5), 40'(20'hFFFFF));
    check("rst_digits4", 40'(digits4), 40'(16'hFFFF));

    launch(16'd0);
    wait_result(16'd0, 1'b0);
    quiet(16'd0, 2);

    // 1234, then load held in the done cycle: accepted on the next edge.
    launch(16'd1234);
    wait_result(16'd1234, 1'b0);
    value = 16'd777;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check("b2b_accept", 40'(ready5), 40'(1'b0));
    check("b2b_done_low", 40'(done5), 40'(1'b0));
    wait_result(16'd777, 1'b0);
    quiet(16'd777, 2);

    launch(16'd65535);
    wait_result(16'd65535, 1'b1);
    quiet(16'd65535, 4);

    launch(16'd12345);
    wait_result(16'd12345, 1'b0);
    quiet(16'd12345, 1);
    launch(16'd9999);
    wait_result(16'd9999, 1'b0);
    quiet(16'd9999, 1);

    // Reset in the middle of a conversion.
    launch(16'd42);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 40'(ready5), 40'(1'b1));
    check("midrst_done", 40'(done5), 40'(1'b0));
    check("midrst_ovf", 40'(ovf5), 40'(1'b0));
    check("midrst_digits5", 40'(digits5), 40'(20'hFFFFF));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done5 !== 1'b0 || digits5 !== 20'hFFFFF) begin
        check("midrst_no_result", {4'd0, 15'd0, done5, digits5}, {4'd0, 15'd0, 1'b0, 20'hFFFFF});
        break;
      end
    end
    check("midrst_quiet_end", 40'(digits5), 40'(20'hFFFFF));
    launch(16'd42);
    wait_result(16'd42, 1'b0);
    quiet(16'd42, 1);

    // Randomized operands around the interesting boundaries.
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 99));
        1:       v = 16'($urandom_range(9990, 10010));
        2:       v = 16'($urandom_range(60000, 65535));
        default: v = 16'($urandom);
      endcase
      launch(v);
      wait_result(v, 1'($urandom_range(0, 1)));
      quiet(v, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
